fetch_unit: RTL and testbench

Parametrised instruction-fetch stage feeding the IF/ID boundary of the pipeline. It holds the PC and issues in-order word fetches over a request/grant/response instruction-memory interface. Returned words are buffered in a small FIFO and presented to decode with a valid/ready handshake. A taken branch from EX/MEM redirects the PC, flushes the FIFO and discards in-flight responses.

---
 rtl/fetch_unit_if.sv | 38 +++
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the redirect input, the instruction-memory
// request/grant/response bus and the IF/ID valid/ready handshake of the
// fetch stage. "master" is the fetch unit side; "slave" is the environment
// (memory, EX/MEM redirect source and decode).
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  // Redirect from EX/MEM.
  logic            EX_MEM_PCSrc;
  logic [XLEN-1:0] EX_MEM_NPC;
  // Instruction memory.
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  // IF/ID boundary.
  logic            IF_ID_valid;
  logic [31:0]     IF_ID_instr;
  logic [XLEN-1:0] IF_ID_npc;
  logic            IF_ID_ready;

  modport master (
    input  EX_MEM_PCSrc, EX_MEM_NPC,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  IF_ID_ready,
    output imem_req, imem_addr,
    output IF_ID_valid, IF_ID_instr, IF_ID_npc
  );

  modport slave (
    output EX_MEM_PCSrc, EX_MEM_NPC,
    output imem_gnt, imem_rvalid, imem_rdata,
    output IF_ID_ready,
    input  imem_req, imem_addr,
    input  IF_ID_valid, IF_ID_instr, IF_ID_npc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch stage. Holds the PC, issues word
// fetches on a request/grant/response memory bus, buffers returned words in a
// small FIFO and hands them to decode. A taken branch redirects the PC,
// flushes the buffer and drops responses still in flight.
//
// Optional feature macro: FETCH_BUBBLE_CNT_EN adds output fetch_bubble_cnt,
// a saturating count of cycles where decode was ready but nothing was valid.
//
// Handshakes:
//   memory : a request transfers on a cycle with imem_req & imem_gnt; one
//            response (imem_rvalid) comes back per grant, in order, at least
//            one cycle later. imem_req/imem_addr are combinational.
//   decode : IF_ID_instr/IF_ID_npc transfer on a cycle with
//            IF_ID_valid & IF_ID_ready; while valid & !ready the head and
//            outputs stay stable. IF_ID_valid drops in a redirect cycle.
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter logic [XLEN-1:0] PC_INCR    = XLEN'(4),
  parameter int              FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  fetch_unit_if.master      bus
`ifdef FETCH_BUBBLE_CNT_EN
  ,
  output logic [31:0]       fetch_bubble_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  // Architectural state.
  logic [XLEN-1:0] r_pc;        // next address to request
  logic [XLEN-1:0] r_resp_pc;   // fetch address of the next kept response
  logic [CW-1:0]   r_out_cnt;   // granted, unanswered requests
  logic [CW-1:0]   r_disc_cnt;  // in-flight responses still to be dropped
  logic [CW-1:0]   r_fcnt;      // buffered instructions
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [31:0]     r_fifo_instr [FIFO_DEPTH];
  logic [XLEN-1:0] r_fifo_npc   [FIFO_DEPTH];

  // Per-cycle events.
  logic            w_redirect;
  logic            w_valid;
  logic            w_pop;
  logic            w_req;
  logic            w_grant;
  logic            w_rsp;
  logic            w_push;
  logic [CW:0]     w_used;

  assign w_redirect = bus.EX_MEM_PCSrc;

  // Redirect suppresses the output so no pop can happen on a flushed entry.
  assign w_valid = (r_fcnt != '0) & ~w_redirect;
  assign w_pop   = w_valid & bus.IF_ID_ready;

  // Credit: every granted request owns a FIFO slot until it is popped (or
  // dropped), so a response can always be pushed. A pop this cycle frees a
  // slot early, which lets a full FIFO keep streaming at one per cycle.
  assign w_used = {1'b0, r_out_cnt} + {1'b0, r_fcnt} - (CW+1)'(w_pop);
  assign w_req  = ~rst & ~w_redirect & (w_used < DEPTH_W);

  assign w_grant = w_req & bus.imem_gnt;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp  = bus.imem_rvalid & (r_out_cnt != '0);
  assign w_push = w_rsp & ~w_redirect & (r_disc_cnt == '0);

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_pc;
  assign bus.IF_ID_valid = w_valid;
  assign bus.IF_ID_instr = r_fifo_instr[r_rd_ptr];
  assign bus.IF_ID_npc   = r_fifo_npc[r_rd_ptr];

  // Request and response PCs: redirect loads both, otherwise each advances
  // on its own event (grant / kept response), wrapping silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc      <= bus.EX_MEM_NPC;
      r_resp_pc <= bus.EX_MEM_NPC;
    end else begin
      if (w_grant) r_pc      <= r_pc + PC_INCR;
      if (w_push)  r_resp_pc <= r_resp_pc + PC_INCR;
    end
  end

  // Outstanding count: up on grant, down on every accepted response
  // (including dropped ones). No grant can coincide with a redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_cnt <= '0;
    end else begin
      r_out_cnt <= r_out_cnt + CW'(w_grant) - CW'(w_rsp);
    end
  end

  // Discard count: on redirect every request still unanswered after this
  // cycle's response becomes stale; afterwards each response burns one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disc_cnt <= '0;
    end else if (w_redirect) begin
      r_disc_cnt <= r_out_cnt - CW'(w_rsp);
    end else if (w_rsp && (r_disc_cnt != '0)) begin
      r_disc_cnt <= r_disc_cnt - CW'(1);
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_fcnt   <= '0;
    end else if (w_redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_fcnt   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_fcnt <= r_fcnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // FIFO storage: each entry is the instruction plus its fall-through PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_instr[i] <= '0;
        r_fifo_npc[i]   <= '0;
      end
    end else if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= bus.imem_rdata;
      r_fifo_npc[r_wr_ptr]   <= r_resp_pc + PC_INCR;
    end
  end

`ifdef FETCH_BUBBLE_CNT_EN
  logic [31:0] r_bubble_cnt;

  // Bubble counter: decode was ready but had nothing to take; saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (bus.IF_ID_ready && !w_valid && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign fetch_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven vectors for reset release and stall, directed
// redirect/wrap sequences, then randomized traffic against a reference model.
// The model tracks the expected instruction stream as "sequential addresses
// from the last reset/redirect target", with an in-order memory whose data
// is a function of the address.
module tb_fetch_unit;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  logic        gnt, ready, pcsrc, rvalid;
  logic [31:0] npc_in, rdata;

  assign bus.imem_gnt     = gnt;
  assign bus.IF_ID_ready  = ready;
  assign bus.EX_MEM_PCSrc = pcsrc;
  assign bus.EX_MEM_NPC   = npc_in;
  assign bus.imem_rvalid  = rvalid;
  assign bus.imem_rdata   = rdata;

`ifdef FETCH_BUBBLE_CNT_EN
  logic [31:0] bubble;
`endif

  fetch_unit #(
    .XLEN(XLEN), .RESET_PC(32'h0), .PC_INCR(32'd4), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_BUBBLE_CNT_EN
    ,
    .fetch_bubble_cnt(bubble)
`endif
  );

  // ---------------- scoreboard / model state ----------------
  typedef struct {
    logic [31:0] data;
    int          due;
  } mem_rsp_t;

  mem_rsp_t    mem_q[$];     // in-order memory pipeline
  int          last_due;
  int          lat_min, lat_max;
  bit          hash_mode;
  int          cyc;
  logic [31:0] exp_pc;       // address of next instruction decode should see
  logic [31:0] exp_req_pc;   // next address the fetch unit should request
  int          tb_buf;       // kept responses not yet consumed by decode
  int          tb_disc;      // in-flight responses that must not surface
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (hash_mode) return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    return a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive this cycle's memory response, then move to the sampling edge.
  task automatic sample_point();
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rvalid = 1'b1;
      rdata  = mem_q[0].data;
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
    end
    @(negedge clk);
  endtask

  // Check the cycle against the model, update the model, cross the edge.
  task automatic advance();
    logic v, r, p;
    int   used, lat, due;
    v    = bus.IF_ID_valid;
    r    = bus.imem_req;
    p    = v & ready;
    used = mem_q.size() + tb_buf - (p ? 1 : 0);
    check("valid_rule", {31'd0, v}, {31'd0, (tb_buf != 0) && !pcsrc});
    check("req_rule",   {31'd0, r}, {31'd0, !pcsrc && (used < DEPTH)});
    if (p) begin
      check("instr", bus.IF_ID_instr, mem_word(exp_pc));
      check("npc",   bus.IF_ID_npc,   exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      if (tb_buf > 0) tb_buf--;
    end
    if (rvalid) begin
      mem_q.delete(0);
      if (!pcsrc) begin
        if (tb_disc > 0) tb_disc--;
        else tb_buf++;
      end
    end
    if (pcsrc) begin
      tb_buf     = 0;
      tb_disc    = mem_q.size();
      exp_pc     = npc_in;
      exp_req_pc = npc_in;
    end
    if (r && gnt) begin
      check("req_addr", bus.imem_addr, exp_req_pc);
      exp_req_pc = exp_req_pc + 32'd4;
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{data: mem_word(bus.imem_addr), due: due});
    end
    @(posedge clk);
    #1;
    cyc++;
    pcsrc = 1'b0;
  endtask

  task automatic step();
    sample_point();
    advance();
  endtask

  // Assert reset (callable mid-stream), check outputs clear at once,
  // then release so the next cycle is cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_req",   {31'd0, bus.imem_req},    32'd0);
    check("rst_valid", {31'd0, bus.IF_ID_valid}, 32'd0);
    check("rst_instr", bus.IF_ID_instr, 32'd0);
    check("rst_npc",   bus.IF_ID_npc,   32'd0);
`ifdef FETCH_BUBBLE_CNT_EN
    check("rst_bubble", bubble, 32'd0);
`endif
    mem_q.delete();
    last_due   = -1;
    tb_buf     = 0;
    tb_disc    = 0;
    exp_pc     = 32'h0;
    exp_req_pc = 32'h0;
    pcsrc      = 1'b0;
    rvalid     = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst_first;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_npc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input bit rf, input bit rd, input bit rq,
                                  input logic [31:0] ad, input bit vl,
                                  input logic [31:0] ins, input logic [31:0] np);
    vecs.push_back('{rst_first: rf, rdy: rd, e_req: rq, e_addr: ad,
                     e_valid: vl, e_instr: ins, e_npc: np});
  endfunction

  // ---------------- main test ----------------
  initial begin
    bit found;
    bit prev_pc;

    rst = 1'b0; gnt = 1'b1; ready = 1'b1; pcsrc = 1'b0; npc_in = '0;
    rvalid = 1'b0; rdata = '0; cyc = 0;
    hash_mode = 1'b0; lat_min = 1; lat_max = 1;
    #1;

    // Reset release, decode always ready: 2-cycle latency then 1/cycle.
    add_vec(1, 1, 1, 32'd0,  0, 32'd0,  32'd0);
    add_vec(0, 1, 1, 32'd4,  0, 32'd0,  32'd0);
    add_vec(0, 1, 1, 32'd8,  1, 32'd0,  32'd4);
    add_vec(0, 1, 1, 32'd12, 1, 32'd4,  32'd8);
    add_vec(0, 1, 1, 32'd16, 1, 32'd8,  32'd12);
    add_vec(0, 1, 1, 32'd20, 1, 32'd12, 32'd16);
    // Stall for 10 cycles from cycle 2: credit stops at 4, head held.
    add_vec(1, 1, 1, 32'd0,  0, 32'd0,  32'd0);
    add_vec(0, 1, 1, 32'd4,  0, 32'd0,  32'd0);
    add_vec(0, 0, 1, 32'd8,  1, 32'd0,  32'd4);
    add_vec(0, 0, 1, 32'd12, 1, 32'd0,  32'd4);
    for (int c = 4; c < 12; c++) add_vec(0, 0, 0, 32'd16, 1, 32'd0, 32'd4);
    add_vec(0, 1, 1, 32'd16, 1, 32'd0,  32'd4);
    add_vec(0, 1, 1, 32'd20, 1, 32'd4,  32'd8);
    add_vec(0, 1, 1, 32'd24, 1, 32'd8,  32'd12);
    add_vec(0, 1, 1, 32'd28, 1, 32'd12, 32'd16);
    add_vec(0, 1, 1, 32'd32, 1, 32'd16, 32'd20);

    foreach (vecs[k]) begin
      if (vecs[k].rst_first) do_reset();
      ready = vecs[k].rdy;
      gnt   = 1'b1;
      sample_point();
      check("tbl_req",   {31'd0, bus.imem_req},    {31'd0, vecs[k].e_req});
      check("tbl_addr",  bus.imem_addr,            vecs[k].e_addr);
      check("tbl_valid", {31'd0, bus.IF_ID_valid}, {31'd0, vecs[k].e_valid});
      if (vecs[k].e_valid) begin
        check("tbl_instr", bus.IF_ID_instr, vecs[k].e_instr);
        check("tbl_npc",   bus.IF_ID_npc,   vecs[k].e_npc);
      end
      advance();
    end

    // Latency 3, redirect to 0x100 with 3 requests outstanding.
    lat_min = 3; lat_max = 3;
    do_reset();
    ready = 1'b1; gnt = 1'b1;
    repeat (3) step();
    pcsrc = 1'b1; npc_in = 32'h100;
    sample_point();
    check("r3_req",   {31'd0, bus.imem_req},    32'd0);
    check("r3_valid", {31'd0, bus.IF_ID_valid}, 32'd0);
    advance();
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      sample_point();
      if (bus.IF_ID_valid) begin
        found = 1'b1;
        check("r3_instr", bus.IF_ID_instr, 32'h100);
        check("r3_npc",   bus.IF_ID_npc,   32'h104);
        check("r3_cycle", cyc, 32'd8);
      end
      advance();
    end
    check("r3_found", {31'd0, found}, 32'd1);

    // Redirect coinciding with a response and a would-be pop.
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (5) step();
    pcsrc = 1'b1; npc_in = 32'h200;
    sample_point();
    check("rs_rvalid_present", {31'd0, rvalid}, 32'd1);
    check("rs_req",   {31'd0, bus.imem_req},    32'd0);
    check("rs_valid", {31'd0, bus.IF_ID_valid}, 32'd0);
    advance();
    sample_point();
    check("rs_n1_valid", {31'd0, bus.IF_ID_valid}, 32'd0);
    check("rs_n1_req",   {31'd0, bus.imem_req},    32'd1);
    check("rs_n1_addr",  bus.imem_addr, 32'h200);
    advance();
    sample_point();
    check("rs_n2_valid", {31'd0, bus.IF_ID_valid}, 32'd0);
    advance();
    sample_point();
    check("rs_n3_valid", {31'd0, bus.IF_ID_valid}, 32'd1);
    check("rs_n3_instr", bus.IF_ID_instr, 32'h200);
    check("rs_n3_npc",   bus.IF_ID_npc,   32'h204);
    advance();

    // PC wrap at the top of the address space; bubble count at cycle 2.
    do_reset();
    step();
    step();
    sample_point();
`ifdef FETCH_BUBBLE_CNT_EN
    check("bubble_c2", bubble, 32'd2);
`endif
    advance();
    repeat (2) step();
    pcsrc = 1'b1; npc_in = 32'hFFFF_FFFC;
    step();
    sample_point();
    check("wr_addr0", bus.imem_addr, 32'hFFFF_FFFC);
    advance();
    sample_point();
    check("wr_req1",  {31'd0, bus.imem_req}, 32'd1);
    check("wr_addr1", bus.imem_addr, 32'h0);
    advance();
    sample_point();
    check("wr_instr", bus.IF_ID_instr, 32'hFFFF_FFFC);
    check("wr_npc",   bus.IF_ID_npc,   32'h0);
    advance();
    sample_point();
    check("wr_npc2",  bus.IF_ID_npc,   32'h4);
    advance();

    // Randomized traffic: grant/ready gaps, variable latency, redirects.
    hash_mode = 1'b1; lat_min = 1; lat_max = 4;
    do_reset();
    prev_pc = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      gnt   = ($urandom_range(3, 0) != 0);
      ready = (i % 300 < 40) ? 1'b0 : ($urandom_range(3, 0) != 0);
      pcsrc = !prev_pc && ($urandom_range(24, 0) == 0);
      npc_in = ($urandom_range(7, 0) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      prev_pc = pcsrc;
      step();
    end

    // Reset in the middle of a stream clears outputs immediately.
    gnt = 1'b1; ready = 1'b1;
    do_reset();
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
